// File: rtl/gpio_ext_pkg.sv
// gpio_ext_pkg: bus geometry, register word indices and warm-up terminal count
// shared by the gpio_ext peripheral, its bus interface and its testbench.
package gpio_ext_pkg;

    // Data bus geometry: 32-bit words, 4 byte strobes, byte addressing
    // (the register index sits above the two byte-offset bits).
    localparam int X1  = 31;
    localparam int WS  = 3;
    localparam int XRL = 2;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t GPIO_DATA = 3'd0;
    localparam reg_idx_t GPIO_SET  = 3'd1;
    localparam reg_idx_t GPIO_CLR  = 3'd2;
    localparam reg_idx_t GPIO_TGL  = 3'd3;
    localparam reg_idx_t GPIO_DIR  = 3'd4;
    localparam reg_idx_t GPIO_IE   = 3'd5;
    localparam reg_idx_t GPIO_IP   = 3'd6;
    localparam reg_idx_t GPIO_EDGE = 3'd7;

    // Edge events stay masked until the post-reset counter reaches this value,
    // long enough for the synchroniser and prev register to fill with real pin levels.
    localparam logic [1:0] GPIO_WARM_TC = 2'd3;

endpackage

// File: rtl/gpio_ext_if.sv
// gpio_ext_if: data-bus slave port of the gpio_ext peripheral.
// The master drives chip-select, read/write enables, strobes, address and
// write data; the slave returns registered read data.
interface gpio_ext_if;
    import gpio_ext_pkg::*;

    logic          dcs;
    logic          drd;
    logic          dwe;
    logic [WS:0]   dwst;
    logic [X1:0]   dadrs;
    logic [X1:0]   din;
    logic [X1:0]   dout;

    modport master (output dcs, drd, dwe, dwst, dadrs, din, input dout);
    modport slave  (input dcs, drd, dwe, dwst, dadrs, din, output dout);
endinterface

// File: rtl/gpio_ext_sync.sv
// gpio_ext_sync: two-flop input synchroniser plus one-cycle history register.
// s2 is the metastability-safe pin level; rise/fall compare s2 against the
// previous cycle's s2.
module gpio_ext_sync
    import gpio_ext_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] d,
    output logic [N-1:0] s2,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] s1_q, s1_d;
    logic [N-1:0] s2_q, s2_d;
    logic [N-1:0] prev_q, prev_d;

    // Shift the pin level through s1 -> s2 -> prev every cycle
    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Synchroniser state, cleared asynchronously so edge history restarts at 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign s2   = s2_q;
    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/gpio_ext.sv
// gpio_ext: N-pin memory-mapped GPIO with per-pin direction, atomic
// set/clear/toggle, synchronised inputs and edge-triggered interrupts.
// Build option: define GPIO_EXT_IRQ_EN to include IE/IP/EDGE, edge detection
// and the warm-up counter; without it registers 5-7 read 0 and irq is 0.
module gpio_ext
    import gpio_ext_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstn,
    gpio_ext_if.slave    bus,
    output logic         irq,
    inout  wire  [N-1:0] io
);

    logic           rd, we;
    reg_idx_t       idx;
    logic [N-1:0]   wv, wm;
    logic [N-1:0]   s2, rise, fall, pin;
    logic [N-1:0]   rd_val;
    logic           unused_bus;

    logic [N-1:0]   data_q, data_d;
    logic [N-1:0]   dir_q, dir_d;
    logic [X1:0]    dout_q, dout_d;

    assign rd  = bus.dcs & bus.drd;
    assign we  = bus.dcs & bus.dwe;
    assign idx = bus.dadrs[XRL+2:XRL];
    assign wv  = bus.din[N-1:0];

    // Address bits outside the index field and data bits above N carry no meaning here
    assign unused_bus = ^{bus.dadrs, bus.din};

    // Per-bit write mask from the byte strobe covering that bit
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign wm[g] = bus.dwst[g/8];
    end

    // Output pins drive data only where the direction bit selects output
    for (genvar g = 0; g < N; g++) begin : g_pad
        assign io[g] = dir_q[g] ? data_q[g] : 1'bz;
    end

    gpio_ext_sync #(.N(N)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (io),
        .s2   (s2),
        .rise (rise),
        .fall (fall)
    );

    // Outputs read back what is driven; inputs read back the synchronised level
    assign pin = (dir_q & data_q) | (~dir_q & s2);

    function automatic logic [N-1:0] wr_merge(input logic [N-1:0] old_v,
                                              input logic [N-1:0] new_v,
                                              input logic [N-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // DATA/SET/CLR/TGL/DIR writes; data is kept even for pins set as inputs
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        if (we) begin
            case (idx)
                GPIO_DATA: data_d = wr_merge(data_q, wv, wm);
                GPIO_SET:  data_d = data_q | (wv & wm);
                GPIO_CLR:  data_d = data_q & ~(wv & wm);
                GPIO_TGL:  data_d = data_q ^ (wv & wm);
                GPIO_DIR:  dir_d  = wr_merge(dir_q, wv, wm);
                default:   ;
            endcase
        end
    end

`ifdef GPIO_EXT_IRQ_EN
    logic [N-1:0]   ie_q, ie_d;
    logic [N-1:0]   ip_q, ip_d;
    logic [N-1:0]   esel_q, esel_d;
    logic [1:0]     warm_q, warm_d;
    logic           warm_done;
    logic [N-1:0]   ev;

    assign warm_done = (warm_q == GPIO_WARM_TC);

    // Edge events on input pins, suppressed until the synchroniser has settled
    always_comb begin
        ev = '0;
        if (warm_done)
            ev = ((esel_q & fall) | (~esel_q & rise)) & ~dir_q;
    end

    // IE/EDGE writes, IP write-1-to-clear with a same-cycle event taking priority
    always_comb begin
        ie_d   = ie_q;
        esel_d = esel_q;
        ip_d   = ip_q;
        warm_d = warm_done ? warm_q : warm_q + 2'd1;
        if (we && idx == GPIO_IE)   ie_d   = wr_merge(ie_q, wv, wm);
        if (we && idx == GPIO_EDGE) esel_d = wr_merge(esel_q, wv, wm);
        if (we && idx == GPIO_IP)   ip_d   = ip_q & ~(wv & wm);
        ip_d = ip_d | ev;
    end

    // Interrupt state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ie_q   <= '0;
            ip_q   <= '0;
            esel_q <= '0;
            warm_q <= '0;
        end else begin
            ie_q   <= ie_d;
            ip_q   <= ip_d;
            esel_q <= esel_d;
            warm_q <= warm_d;
        end
    end

    assign irq = |(ip_q & ie_q);
`else
    logic unused_edges;
    assign unused_edges = |{rise, fall};
    assign irq = 1'b0;
`endif

    // Read mux; unimplemented registers and bits above N read 0
    always_comb begin
        rd_val = '0;
        case (idx)
            GPIO_DATA, GPIO_SET, GPIO_CLR, GPIO_TGL: rd_val = pin;
            GPIO_DIR:  rd_val = dir_q;
`ifdef GPIO_EXT_IRQ_EN
            GPIO_IE:   rd_val = ie_q;
            GPIO_IP:   rd_val = ip_q;
            GPIO_EDGE: rd_val = esel_q;
`endif
            default:   rd_val = '0;
        endcase
    end

    // Registered read data, held while no read is in progress
    always_comb begin
        dout_d = dout_q;
        if (rd) begin
            dout_d          = '0;
            dout_d[N-1:0]   = rd_val;
        end
    end

    // Core register file
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            dir_q  <= '0;
            dout_q <= '0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;

endmodule

// File: tb/tb_gpio_ext.sv
// tb_gpio_ext: self-checking bench for gpio_ext (N = 12, so both the byte
// strobes and the bits above N are exercised). Expectations come from a
// register-level model; interrupt expectations follow GPIO_EXT_IRQ_EN.
module tb_gpio_ext;
    import gpio_ext_pkg::*;

    localparam int N = 12;
`ifdef GPIO_EXT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         irq;
    wire  [N-1:0] io;
    logic [N-1:0] tb_val;
    logic [N-1:0] tb_oe;

    int n_run  = 0;
    int n_fail = 0;

    // Model state
    logic [N-1:0] m_data, m_dir, m_ie, m_ip, m_edge;

    always #5 clk = ~clk;

    gpio_ext_if bus ();

    gpio_ext #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .irq  (irq),
        .io   (io)
    );

    // External pin drivers: the bench drives every pin the model holds as input
    assign tb_oe = ~m_dir;
    for (genvar g = 0; g < N; g++) begin : g_ext
        assign io[g] = tb_oe[g] ? tb_val[g] : 1'bz;
    end

    function automatic logic [N-1:0] lanes(input logic [3:0] stb);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = stb[i/8];
        return m;
    endfunction

    function automatic void model_write(input reg_idx_t idx, input logic [31:0] val,
                                        input logic [3:0] stb);
        logic [N-1:0] lm, v;
        lm = lanes(stb);
        v  = val[N-1:0] & lm;
        case (idx)
            GPIO_DATA: m_data = (m_data & ~lm) | v;
            GPIO_SET:  m_data = m_data | v;
            GPIO_CLR:  m_data = m_data & ~v;
            GPIO_TGL:  m_data = m_data ^ v;
            GPIO_DIR:  m_dir  = (m_dir & ~lm) | v;
            GPIO_IE:   if (IRQ_EN) m_ie   = (m_ie & ~lm) | v;
            GPIO_IP:   if (IRQ_EN) m_ip   = m_ip & ~v;
            GPIO_EDGE: if (IRQ_EN) m_edge = (m_edge & ~lm) | v;
            default:   ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input reg_idx_t idx);
        logic [N-1:0] pins, r;
        logic [31:0]  w;
        pins = (m_dir & m_data) | (~m_dir & tb_val);
        case (idx)
            GPIO_DATA, GPIO_SET, GPIO_CLR, GPIO_TGL: r = pins;
            GPIO_DIR:  r = m_dir;
            GPIO_IE:   r = IRQ_EN ? m_ie : '0;
            GPIO_IP:   r = IRQ_EN ? m_ip : '0;
            default:   r = IRQ_EN ? m_edge : '0;
        endcase
        w = '0;
        w[N-1:0] = r;
        return w;
    endfunction

    // New interrupt events implied by a settled pin change
    function automatic void model_pins(input logic [N-1:0] old_v, input logic [N-1:0] new_v);
        logic [N-1:0] rise, fall;
        rise = new_v & ~old_v;
        fall = ~new_v & old_v;
        if (IRQ_EN) m_ip = m_ip | (((m_edge & fall) | (~m_edge & rise)) & ~m_dir);
    endfunction

    function automatic void model_reset();
        m_data = '0; m_dir = '0; m_ie = '0; m_ip = '0; m_edge = '0;
    endfunction

    function automatic logic exp_irq();
        return IRQ_EN && ((m_ip & m_ie) != '0);
    endfunction

    task automatic wr(input reg_idx_t idx, input logic [31:0] val, input logic [3:0] stb);
        @(negedge clk);
        bus.dcs = 1'b1; bus.dwe = 1'b1; bus.drd = 1'b0;
        bus.dadrs = 32'(idx) << XRL; bus.din = val; bus.dwst = stb;
        @(negedge clk);
        bus.dcs = 1'b0; bus.dwe = 1'b0;
        model_write(idx, val, stb);
    endtask

    task automatic rd(input reg_idx_t idx, output logic [31:0] v);
        @(negedge clk);
        bus.dcs = 1'b1; bus.drd = 1'b1; bus.dwe = 1'b0;
        bus.dadrs = 32'(idx) << XRL;
        @(negedge clk);
        v = bus.dout;
        bus.dcs = 1'b0; bus.drd = 1'b0;
    endtask

    // Return every pin to input and clear anything latched while pins changed role
    task automatic settle_inputs();
        wr(GPIO_DIR, 32'h0, 4'hF);
        repeat (6) @(posedge clk);
        wr(GPIO_IP, 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #1;
        n_run++; if (bus.dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0", bus.dout); end
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        rd(GPIO_DIR, v);
        n_run++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_dir got %h want 0", v); end
        for (int r = 5; r < 8; r++) begin
            rd(reg_idx_t'(r), v);
            n_run++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d got %h want 0", r, v); end
        end
    endtask

    task automatic test_direction();
        logic [31:0] v;
        tb_val = 12'h350;
        wr(GPIO_DIR, 32'h0F, 4'hF);
        wr(GPIO_DATA, 32'hA5, 4'hF);
        #1;
        n_run++; if (io[3:0] !== 4'h5) begin n_fail++; $display("FAIL dir_io_out got %h want 5", io[3:0]); end
        n_run++; if (io[11:4] !== 8'h35) begin n_fail++; $display("FAIL dir_io_in got %h want 35", io[11:4]); end
        repeat (3) @(posedge clk);
        rd(GPIO_DATA, v);
        n_run++; if (v !== 32'h355) begin n_fail++; $display("FAIL dir_pin_read got %h want 355", v); end
        rd(GPIO_DIR, v);
        n_run++; if (v !== 32'h00F) begin n_fail++; $display("FAIL dir_read got %h want 00f", v); end
    endtask

    task automatic test_atomic();
        logic [31:0] v, held;
        wr(GPIO_DATA, 32'h00, 4'hF);
        wr(GPIO_DIR, 32'hFF, 4'hF);
        wr(GPIO_SET, 32'h81, 4'hF);
        rd(GPIO_DATA, v);
        n_run++; if (v[7:0] !== 8'h81) begin n_fail++; $display("FAIL atomic_set got %h want 81", v[7:0]); end
        wr(GPIO_CLR, 32'h01, 4'hF);
        rd(GPIO_DATA, v);
        n_run++; if (v[7:0] !== 8'h80) begin n_fail++; $display("FAIL atomic_clr got %h want 80", v[7:0]); end
        wr(GPIO_TGL, 32'hFF, 4'hF);
        rd(GPIO_DATA, v);
        n_run++; if (v[7:0] !== 8'h7F) begin n_fail++; $display("FAIL atomic_tgl got %h want 7f", v[7:0]); end
        n_run++; if (v !== model_read(GPIO_DATA)) begin n_fail++; $display("FAIL atomic_full got %h want %h", v, model_read(GPIO_DATA)); end
        n_run++; if (io[7:0] !== 8'h7F) begin n_fail++; $display("FAIL atomic_io got %h want 7f", io[7:0]); end
        // Read enable without chip-select must leave dout alone
        held = v;
        @(negedge clk);
        bus.drd = 1'b1; bus.dadrs = 32'(GPIO_DIR) << XRL;
        repeat (3) @(negedge clk);
        bus.drd = 1'b0;
        n_run++; if (bus.dout !== held) begin n_fail++; $display("FAIL dout_hold got %h want %h", bus.dout, held); end
    endtask

    task automatic test_rising();
        logic [31:0] v;
        settle_inputs();
        wr(GPIO_EDGE, 32'h0, 4'hF);
        wr(GPIO_IE, 32'h04, 4'hF);
        @(negedge clk);
        tb_val[2] = 1'b1;
        @(posedge clk); #1;
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_edge1 got %b want 0", irq); end
        @(posedge clk); #1;
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_edge2 got %b want 0", irq); end
        @(posedge clk); #1;
        model_pins(12'h350, 12'h354);
        n_run++; if (irq !== IRQ_EN) begin n_fail++; $display("FAIL rise_irq_edge3 got %b want %b", irq, IRQ_EN); end
        rd(GPIO_IP, v);
        n_run++; if (v !== (IRQ_EN ? 32'h4 : 32'h0)) begin n_fail++; $display("FAIL rise_ip got %h want %h", v, IRQ_EN ? 32'h4 : 32'h0); end
        wr(GPIO_IP, 32'h04, 4'hF);
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_w1c_irq got %b want 0", irq); end
    endtask

    task automatic test_falling_warmup();
        logic [31:0] v;
        logic [N-1:0] old_v;
        rd(GPIO_DATA, v);
        tb_val = 12'h020;
        repeat (3) @(posedge clk);
        // Reset lands mid-cycle: state must clear without a clock edge
        #2 rstn = 1'b0;
        #1;
        model_reset();
        n_run++; if (bus.dout !== 32'h0) begin n_fail++; $display("FAIL async_rst_dout got %h want 0 (was %h)", bus.dout, v); end
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL async_rst_irq got %b want 0", irq); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(posedge clk);
        rd(GPIO_IP, v);
        n_run++; if (v !== 32'h0) begin n_fail++; $display("FAIL warmup_ip got %h want 0", v); end
        wr(GPIO_EDGE, 32'h20, 4'hF);
        wr(GPIO_IE, 32'h20, 4'hF);
        old_v = tb_val;
        tb_val[5] = 1'b0;
        repeat (4) @(posedge clk); #1;
        model_pins(old_v, tb_val);
        n_run++; if (irq !== exp_irq()) begin n_fail++; $display("FAIL fall_irq got %b want %b", irq, exp_irq()); end
        rd(GPIO_IP, v);
        n_run++; if (v !== model_read(GPIO_IP)) begin n_fail++; $display("FAIL fall_ip got %h want %h", v, model_read(GPIO_IP)); end
        // Rising edge on a falling-configured pin must not add anything
        old_v = tb_val;
        tb_val[5] = 1'b1;
        repeat (4) @(posedge clk);
        model_pins(old_v, tb_val);
        // Fall sets IP at the same edge that samples the W1C write
        @(negedge clk);
        tb_val[5] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.dcs = 1'b1; bus.dwe = 1'b1; bus.dadrs = 32'(GPIO_IP) << XRL;
        bus.din = 32'h20; bus.dwst = 4'hF;
        @(negedge clk);
        bus.dcs = 1'b0; bus.dwe = 1'b0;
        model_write(GPIO_IP, 32'h20, 4'hF);
        model_pins(12'h020, 12'h000);
        rd(GPIO_IP, v);
        n_run++; if (v !== (IRQ_EN ? 32'h20 : 32'h0)) begin n_fail++; $display("FAIL w1c_vs_set got %h want %h", v, IRQ_EN ? 32'h20 : 32'h0); end
        wr(GPIO_IP, 32'h20, 4'hF);
        rd(GPIO_IP, v);
        n_run++; if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_clear got %h want 0", v); end
    endtask

    task automatic test_strobes();
        logic [31:0] v;
        wr(GPIO_DIR, 32'hFFFF_FFFF, 4'b0010);
        rd(GPIO_DIR, v);
        n_run++; if (v !== 32'h0000_0F00) begin n_fail++; $display("FAIL strobe_dir got %h want 00000f00", v); end
        wr(GPIO_DATA, 32'hFFFF_FFFF, 4'b0001);
        #1;
        n_run++; if (io[11:8] !== 4'h0) begin n_fail++; $display("FAIL strobe_data_io got %h want 0", io[11:8]); end
        rd(GPIO_DATA, v);
        n_run++; if (v !== model_read(GPIO_DATA)) begin n_fail++; $display("FAIL strobe_data_rd got %h want %h", v, model_read(GPIO_DATA)); end
        settle_inputs();
    endtask

    task automatic test_random();
        logic [31:0]  v, exp;
        logic [N-1:0] old_v;
        reg_idx_t     idx;
        for (int ph = 0; ph < 3; ph++) begin
            wr(GPIO_DIR, $urandom, 4'hF);
            repeat (6) @(posedge clk);
            wr(GPIO_IP, 32'hFFFF_FFFF, 4'hF);
            wr(GPIO_EDGE, $urandom, 4'hF);
            wr(GPIO_IE, $urandom, 4'hF);
            for (int k = 0; k < 40; k++) begin
                case ($urandom_range(0, 2))
                    0: begin
                        idx = reg_idx_t'($urandom_range(0, 6));
                        if (idx >= GPIO_DIR) idx = idx + 3'd1;
                        wr(idx, $urandom, 4'($urandom));
                        #1;
                        n_run++;
                        if ((io & m_dir) !== (m_data & m_dir)) begin
                            n_fail++; $display("FAIL rand_io got %h want %h", io & m_dir, m_data & m_dir);
                        end
                    end
                    1: begin
                        idx = reg_idx_t'($urandom_range(0, 7));
                        rd(idx, v);
                        exp = model_read(idx);
                        n_run++;
                        if (v !== exp) begin n_fail++; $display("FAIL rand_rd%0d got %h want %h", idx, v, exp); end
                    end
                    default: begin
                        old_v  = tb_val;
                        tb_val = N'($urandom);
                        repeat (4) @(posedge clk); #1;
                        model_pins(old_v, tb_val);
                        n_run++;
                        if (irq !== exp_irq()) begin n_fail++; $display("FAIL rand_irq got %b want %b", irq, exp_irq()); end
                    end
                endcase
            end
        end
    endtask

    initial begin
        bus.dcs = 1'b0; bus.drd = 1'b0; bus.dwe = 1'b0;
        bus.dwst = '0; bus.dadrs = '0; bus.din = '0;
        tb_val = '0;
        model_reset();
        test_reset();
        test_direction();
        test_atomic();
        test_rising();
        test_falling_warmup();
        test_strobes();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d checks", n_run);
        $fatal(1, "watchdog");
    end

endmodule
